// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback and drives the
// datapath selects, ALU opcode and unified-memory handshake; counts retired instructions.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [31:0]      INSTR,
   input  logic             ZERO,
   input  logic             MEM_READY,
   output logic             MEM_VALID,
   output logic             MEM_WE,
   output logic             ADDR_SRC,
   output logic             IR_WE,
   output logic             PC_WE,
   output logic             REG_WE,
   output logic [1:0]       ALU_SRC_A,
   output logic [1:0]       ALU_SRC_B,
   output logic [1:0]       RESULT_SRC,
   output logic [2:0]       IMM_SRC,
   output logic [3:0]       ALU_OP,
   output logic             ILLEGAL,
   output logic [CNT_W-1:0] INSTRET
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
      S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_instret;
   logic [6:0]       w_opcode;
   logic [2:0]       w_funct3;
   logic             w_b30;
   logic             w_taken;
   logic             w_br_ok;
   logic             w_retire;
   logic             w_unused;

   assign w_opcode = INSTR[6:0];
   assign w_funct3 = INSTR[14:12];
   assign w_b30    = INSTR[30];
   assign w_unused = ^{INSTR[31], INSTR[29:15], INSTR[11:7]};
   assign INSTRET  = r_instret;
   assign ILLEGAL  = (r_state == S_TRAP);

   // INSTR[30] selects SUB only for R-type; SRA/SRL is chosen by it for both forms
   function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic b30,
                                           input logic is_r);
      case (f3)
         3'b000:  f_alu_op = (is_r && b30) ? ALU_SUB : ALU_ADD;
         3'b001:  f_alu_op = ALU_SLL;
         3'b010:  f_alu_op = ALU_SLT;
         3'b011:  f_alu_op = ALU_SLTU;
         3'b100:  f_alu_op = ALU_XOR;
         3'b101:  f_alu_op = b30 ? ALU_SRA : ALU_SRL;
         3'b110:  f_alu_op = ALU_OR;
         default: f_alu_op = ALU_AND;
      endcase
   endfunction

   function automatic logic [2:0] f_imm_src(input logic [6:0] op);
      case (op)
         OP_STORE:  f_imm_src = IMM_S;
         OP_BRANCH: f_imm_src = IMM_B;
         OP_JAL:    f_imm_src = IMM_J;
         OP_LUI:    f_imm_src = IMM_U;
         default:   f_imm_src = IMM_I;
      endcase
   endfunction

   // Signed/unsigned compares produce 1 when less-than, so ZERO means "not less"
   always_comb begin
      w_taken = 1'b0;
      w_br_ok = 1'b1;
      case (w_funct3)
         3'b000:         w_taken = ZERO;
         3'b001:         w_taken = !ZERO;
         3'b100, 3'b110: w_taken = !ZERO;
         3'b101, 3'b111: w_taken = ZERO;
         default:        w_br_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (MEM_READY) w_next = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE:          w_next = S_EXECR;
               OP_ITYPE:          w_next = S_EXECI;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = S_JALR;
               OP_LUI:            w_next = S_LUI;
               default:           w_next = S_TRAP;
            endcase
         end
         S_MEMADR:   w_next = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (MEM_READY) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: if (MEM_READY) w_next = S_FETCH;
         S_EXECR,
         S_EXECI:    w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = w_br_ok ? S_FETCH : S_TRAP;
         S_JALR:     w_next = S_JAL;
         S_JAL:      w_next = S_ALUWB;
         S_LUI:      w_next = S_FETCH;
         default:    w_next = S_TRAP;
      endcase
   end

   assign w_retire = (r_state == S_ALUWB) || (r_state == S_MEMWB) || (r_state == S_LUI) ||
                     ((r_state == S_MEMWRITE) && MEM_READY) ||
                     ((r_state == S_BRANCH) && w_br_ok);

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_state   <= S_FETCH;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_instret <= r_instret + CNT_W'(1);
      end
   end

   always_comb begin
      MEM_VALID  = 1'b0;
      MEM_WE     = 1'b0;
      ADDR_SRC   = 1'b0;
      IR_WE      = 1'b0;
      PC_WE      = 1'b0;
      REG_WE     = 1'b0;
      ALU_SRC_A  = 2'b00;
      ALU_SRC_B  = 2'b00;
      RESULT_SRC = 2'b00;
      IMM_SRC    = IMM_I;
      ALU_OP     = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            MEM_VALID  = 1'b1;
            ALU_SRC_B  = 2'b10;
            RESULT_SRC = 2'b10;
            IR_WE      = MEM_READY;
            PC_WE      = MEM_READY;
         end
         S_DECODE: begin
            ALU_SRC_A = 2'b01;
            ALU_SRC_B = 2'b01;
            IMM_SRC   = f_imm_src(w_opcode);
         end
         S_MEMADR: begin
            ALU_SRC_A = 2'b10;
            ALU_SRC_B = 2'b01;
            IMM_SRC   = f_imm_src(w_opcode);
         end
         S_MEMREAD: begin
            MEM_VALID = 1'b1;
            ADDR_SRC  = 1'b1;
         end
         S_MEMWB: begin
            RESULT_SRC = 2'b01;
            REG_WE     = 1'b1;
         end
         S_MEMWRITE: begin
            MEM_VALID = 1'b1;
            MEM_WE    = 1'b1;
            ADDR_SRC  = 1'b1;
         end
         S_EXECR: begin
            ALU_SRC_A = 2'b10;
            ALU_OP    = f_alu_op(w_funct3, w_b30, 1'b1);
         end
         S_EXECI: begin
            ALU_SRC_A = 2'b10;
            ALU_SRC_B = 2'b01;
            ALU_OP    = f_alu_op(w_funct3, w_b30, 1'b0);
         end
         S_ALUWB: REG_WE = 1'b1;
         S_BRANCH: begin
            ALU_SRC_A = 2'b10;
            PC_WE     = w_taken;
            case (w_funct3[2:1])
               2'b00:   ALU_OP = ALU_SUB;
               2'b10:   ALU_OP = ALU_SLT;
               2'b11:   ALU_OP = ALU_SLTU;
               default: ALU_OP = ALU_ADD;
            endcase
         end
         S_JALR: begin
            ALU_SRC_A = 2'b10;
            ALU_SRC_B = 2'b01;
         end
         // Target already sits in ALU_OUT; the ALU computes the link value OLD_PC+4
         S_JAL: begin
            ALU_SRC_A = 2'b01;
            ALU_SRC_B = 2'b10;
            PC_WE     = 1'b1;
         end
         S_LUI: begin
            IMM_SRC    = IMM_U;
            RESULT_SRC = 2'b11;
            REG_WE     = 1'b1;
         end
         default: ;
      endcase
      // Holding reset aborts any in-flight memory access immediately
      if (!RSTN) begin
         MEM_VALID = 1'b0;
         MEM_WE    = 1'b0;
         IR_WE     = 1'b0;
         PC_WE     = 1'b0;
         REG_WE    = 1'b0;
      end
   end

endmodule
